// File: rtl/ram4_bank_pkg.sv
// Shared definitions for the 4-word register bank: clear sequencer states and default width.
package ram4_bank_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int NUM_WORDS     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/ram4_bank_dmux.sv
// 1-to-4 demultiplexer: routes the single input to output a..d selected by sel.
module DMux4Way (
    input  logic       in,
    input  logic [1:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
);

    always_comb begin
        a = 1'b0;
        b = 1'b0;
        c = 1'b0;
        d = 1'b0;
        case (sel)
            2'd0:    a = in;
            2'd1:    b = in;
            2'd2:    c = in;
            2'd3:    d = in;
            default: ;
        endcase
    end

endmodule

// File: rtl/ram4_bank_word_reg.sv
// One storage word: WIDTH-bit register with load enable and async active-low reset.
module word_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ram4_bank.sv
// 4-word register bank with combinational read, decoded writes, per-word valid flags
// and a self-timed sequencer that zeroes one word per cycle on request.
module ram4_bank
    import ram4_bank_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       addr,
    input  logic             load,
    input  logic             clear_start,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       valid,
    output logic             load_ack,
    output logic             clear_busy,
    output logic             clear_done
);

    clr_state_e       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             clear_done_q, clear_done_d;
    logic [3:0]       valid_q, valid_d;
    logic             clr_en;
    logic             load_gated;
    logic [3:0]       we;
    logic [3:0]       clr_sel;
    logic [WIDTH-1:0] words [NUM_WORDS];

    assign clear_busy = (state_q != S_IDLE);
    assign load_gated = load & ~clear_busy;
    assign load_ack   = load_gated;

    DMux4Way u_load_dmux (
        .in  (load_gated),
        .sel (addr),
        .a   (we[0]),
        .b   (we[1]),
        .c   (we[2]),
        .d   (we[3])
    );

    DMux4Way u_clr_dmux (
        .in  (clr_en),
        .sel (ptr_q),
        .a   (clr_sel[0]),
        .b   (clr_sel[1]),
        .c   (clr_sel[2]),
        .d   (clr_sel[3])
    );

    // Writes are blocked while busy, so a word never sees both a write and a clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            word_reg #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (we[gi] | clr_sel[gi]),
                .d     (clr_sel[gi] ? '0 : in),
                .q     (words[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clear_done_d = 1'b0;
        clr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    ptr_d   = 2'd0;
                end
            end
            S_CLEAR: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + 2'd1;
                if (ptr_q == 2'd3) begin
                    state_d      = S_DONE;
                    clear_done_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            valid_d[i] = clr_sel[i] ? 1'b0 : (valid_q[i] | we[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= 2'd0;
            clear_done_q <= 1'b0;
            valid_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clear_done_q <= clear_done_d;
            valid_q      <= valid_d;
        end
    end

    assign out        = words[addr];
    assign valid      = valid_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ram4_bank.sv
// Directed bench for ram4_bank: a bench-side memory model feeds a queue of expected
// read values that is drained when the DUT output is sampled.
module tb_ram4_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [1:0]  addr;
    logic        load;
    logic        clear_start;
    logic [15:0] dout;
    logic [3:0]  valid;
    logic        load_ack;
    logic        clear_busy;
    logic        clear_done;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_mem [4];
    logic [3:0]  m_valid;
    logic [15:0] exp_q [$];

    ram4_bank #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (din),
        .addr        (addr),
        .load        (load),
        .clear_start (clear_start),
        .out         (dout),
        .valid       (valid),
        .load_ack    (load_ack),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_mem[i] = 16'h0000;
        m_valid = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] a, input string tag);
        addr = a;
        load = 1'b0;
        exp_q.push_back(m_mem[a]);
        #1;
        chk(tag, {16'h0, dout}, {16'h0, exp_q.pop_front()});
        $display("read  addr=%0d out=%h", a, dout);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input string tag);
        addr = a;
        din  = d;
        load = 1'b1;
        exp_q.push_back(m_mem[a]);
        #1;
        chk({tag, "_ack"}, {31'h0, load_ack}, 32'h1);
        chk({tag, "_old"}, {16'h0, dout}, {16'h0, exp_q.pop_front()});
        tick();
        m_mem[a]   = d;
        m_valid[a] = 1'b1;
        load = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    initial begin
        rst_n       = 1'b0;
        din         = 16'h0;
        addr        = 2'd0;
        load        = 1'b0;
        clear_start = 1'b0;
        model_clear();

        // 1: reset state
        #1;
        chk("rst_out", {16'h0, dout}, 32'h0);
        chk("rst_busy", {31'h0, clear_busy}, 32'h0);
        chk("rst_done", {31'h0, clear_done}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), "t1_out");
            chk("t1_valid", {28'h0, valid}, 32'h0);
        end

        // 2: two writes, one-cycle read-after-write
        wr(2'd0, 16'h1234, "t2_w0");
        rd(2'd0, "t2_rd0");
        wr(2'd3, 16'hBEEF, "t2_w3");
        rd(2'd3, "t2_rd3");
        rd(2'd0, "t2_rd0b");
        chk("t2_valid", {28'h0, valid}, {28'h0, m_valid});

        // 3: full clear with a load held during busy and a re-request ignored
        wr(2'd0, 16'h1111, "t3_w0");
        wr(2'd1, 16'h2222, "t3_w1");
        wr(2'd2, 16'h3333, "t3_w2");
        wr(2'd3, 16'h4444, "t3_w3");
        chk("t3_valid_full", {28'h0, valid}, 32'hF);
        clear_start = 1'b1;
        load        = 1'b0;
        tick();
        clear_start = 1'b0;
        addr        = 2'd2;
        din         = 16'h5555;
        load        = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic exp_ack;
            clear_start = (k == 2);
            #1;
            exp_ack = (k >= 5) && load;
            chk("t3_busy", {31'h0, clear_busy}, {31'h0, (k < 5)});
            chk("t3_done", {31'h0, clear_done}, {31'h0, (k == 4)});
            chk("t3_ack", {31'h0, load_ack}, {31'h0, exp_ack});
            $display("clear cycle=%0d busy=%b done=%b ack=%b", k, clear_busy, clear_done, load_ack);
            if (k >= 5) load = 1'b0;
            tick();
        end
        clear_start = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) rd(2'(i), "t3_rd");
        chk("t3_valid", {28'h0, valid}, 32'h0);

        // 4: write and clear request in the same idle cycle
        addr        = 2'd1;
        din         = 16'hAAAA;
        load        = 1'b1;
        clear_start = 1'b1;
        #1;
        chk("t4_ack", {31'h0, load_ack}, 32'h1);
        tick();
        load        = 1'b0;
        clear_start = 1'b0;
        m_mem[1]    = 16'hAAAA;
        m_valid[1]  = 1'b1;
        rd(2'd1, "t4_rd_new");
        chk("t4_valid", {28'h0, valid}, 32'h2);
        chk("t4_busy", {31'h0, clear_busy}, 32'h1);
        for (int k = 0; k < 5; k++) tick();
        model_clear();
        rd(2'd1, "t4_rd_clr");
        chk("t4_busy_end", {31'h0, clear_busy}, 32'h0);
        chk("t4_valid_end", {28'h0, valid}, 32'h0);

        // 5: reset during the second CLEAR cycle
        wr(2'd3, 16'h7777, "t5_w3");
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        addr        = 2'd3;
        tick();
        #1;
        chk("t5_pre_out", {16'h0, dout}, 32'h7777);
        chk("t5_pre_busy", {31'h0, clear_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("t5_out", {16'h0, dout}, 32'h0);
        chk("t5_busy", {31'h0, clear_busy}, 32'h0);
        chk("t5_valid", {28'h0, valid}, 32'h0);
        chk("t5_done", {31'h0, clear_done}, 32'h0);
        #3 rst_n = 1'b1;
        tick();
        chk("t5_busy_after", {31'h0, clear_busy}, 32'h0);
        $display("reset mid-clear out=%h busy=%b valid=%b", dout, clear_busy, valid);

        // 6: back-to-back writes to the same word
        wr(2'd0, 16'h1111, "t6_w0");
        wr(2'd2, 16'h0001, "t6_w2a");
        wr(2'd2, 16'hFFFF, "t6_w2b");
        rd(2'd2, "t6_rd2");
        rd(2'd0, "t6_rd0");
        rd(2'd1, "t6_rd1");
        rd(2'd3, "t6_rd3");
        chk("t6_valid", {28'h0, valid}, {28'h0, m_valid});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
